// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Holds the op codes, FSM states and the per-operation context latched at start.
package muldiv_pkg;

    localparam int MD_W     = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = $clog2(MD_ITER);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Everything the completion step needs to turn the raw magnitude result into HI/LO.
    typedef struct packed {
        logic            is_mul;
        logic            neg_lo;
        logic            neg_hi;
        logic            div0;
        logic [MD_W-1:0] a;
    } md_ctx_t;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes at start, sign correction and
// divide-by-zero override of the raw iterative result at completion.
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [MD_W-1:0]   a,
    input  logic [MD_W-1:0]   b,
    output logic [MD_W-1:0]   mag_a,
    output logic [MD_W-1:0]   mag_b,
    output md_ctx_t           ctx,
    input  md_ctx_t           run_ctx,
    input  logic [2*MD_W-1:0] raw,
    output logic [MD_W-1:0]   res_hi,
    output logic [MD_W-1:0]   res_lo
);

    logic is_signed;
    logic sign_a;
    logic sign_b;
    logic [2*MD_W-1:0] prod;

    // NOTE: combinational blocks use blocking '=' and assign every output on every
    // path, so no latch can be inferred.
    always_comb begin
        is_signed  = (op == OP_MULT) || (op == OP_DIV);
        sign_a     = is_signed & a[MD_W-1];
        sign_b     = is_signed & b[MD_W-1];
        mag_a      = sign_a ? -a : a;
        mag_b      = sign_b ? -b : b;
        ctx.is_mul = (op == OP_MULT) || (op == OP_MULTU);
        ctx.neg_lo = sign_a ^ sign_b;
        ctx.neg_hi = sign_a;
        ctx.div0   = !ctx.is_mul && (b == '0);
        ctx.a      = a;
    end

    // Remainder takes the dividend's sign; quotient and product take sign(a)^sign(b).
    always_comb begin
        prod   = run_ctx.neg_lo ? -raw : raw;
        res_hi = run_ctx.neg_hi ? -raw[2*MD_W-1:MD_W] : raw[2*MD_W-1:MD_W];
        res_lo = run_ctx.neg_lo ? -raw[MD_W-1:0] : raw[MD_W-1:0];
        if (run_ctx.is_mul) begin
            res_hi = prod[2*MD_W-1:MD_W];
            res_lo = prod[MD_W-1:0];
        end else if (run_ctx.div0) begin
            res_hi = run_ctx.a;
            res_lo = '1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, 32 cycles per operation, cancellable.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [MD_W-1:0] a,
    input  logic [MD_W-1:0] b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [MD_W-1:0] hi,
    output logic [MD_W-1:0] lo
);

    md_state_e         state;
    logic [MD_CNT_W-1:0] cnt;
    logic [2*MD_W-1:0] acc;
    logic [2*MD_W-1:0] step_acc;
    logic [MD_W-1:0]   dsor;
    logic [MD_W-1:0]   mag_a;
    logic [MD_W-1:0]   mag_b;
    logic [MD_W-1:0]   res_hi;
    logic [MD_W-1:0]   res_lo;
    md_ctx_t           ctx_d;
    md_ctx_t           ctx_q;
    logic              accept;
    logic [MD_W:0]     mul_sum;
    logic [MD_W:0]     rem_sh;
    logic              rem_ge;
    logic [MD_W-1:0]   rem_sub;

    muldiv_signfix u_signfix (
        .op      (op),
        .a       (a),
        .b       (b),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .ctx     (ctx_d),
        .run_ctx (ctx_q),
        .raw     (step_acc),
        .res_hi  (res_hi),
        .res_lo  (res_lo)
    );

    assign accept = start && !cancel && (state == ST_IDLE);

    // acc = {partial product | remainder, multiplier | dividend->quotient}; dsor holds |b|.
    always_comb begin
        mul_sum = {1'b0, acc[2*MD_W-1:MD_W]} + {1'b0, dsor};
        rem_sh  = {acc[2*MD_W-1:MD_W], acc[MD_W-1]};
        rem_ge  = rem_sh >= {1'b0, dsor};
        rem_sub = rem_sh[MD_W-1:0] - dsor;
        if (ctx_q.is_mul) begin
            step_acc = acc[0] ? {mul_sum, acc[MD_W-1:1]} : {1'b0, acc[2*MD_W-1:1]};
        end else begin
            step_acc = rem_ge ? {rem_sub, acc[MD_W-2:0], 1'b1}
                              : {rem_sh[MD_W-1:0], acc[MD_W-2:0], 1'b0};
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath registers are plain flops, not a memory, so they are
            // reset along with the control state and never show X.
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            dsor  <= '0;
            ctx_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (is_iterative(op)) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            acc   <= {{MD_W{1'b0}}, mag_a};
                            dsor  <= mag_b;
                            ctx_q <= ctx_d;
                        end
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        acc <= step_acc;
                        if (cnt == MD_CNT_W'(MD_ITER - 1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            cnt   <= '0;
                            hi    <= res_hi;
                            lo    <= res_lo;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized operands against
// an arithmetic reference model, cancel/reset/ignored-start and back-to-back scenarios.
module tb_muldiv_unit;

    localparam logic [2:0] OPC_MULT  = 3'b000;
    localparam logic [2:0] OPC_MULTU = 3'b001;
    localparam logic [2:0] OPC_DIV   = 3'b010;
    localparam logic [2:0] OPC_DIVU  = 3'b011;
    localparam logic [2:0] OPC_MTHI  = 3'b100;
    localparam logic [2:0] OPC_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int     sx;
        int     sy;
        longint p;
        sx = x;
        sy = y;
        case (o)
            OPC_MULT: begin
                p = longint'(sx) * longint'(sy);
                return p;
            end
            OPC_MULTU: return {32'h0, x} * {32'h0, y};
            OPC_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            OPC_DIVU: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; issues one start and waits (bounded) for busy to drop.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output logic dn);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        dn = done;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'b0;
        a      = 32'h0;
        b      = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_hilo got %08h_%08h want 0_0", hi, lo);
        end
        reset = 1'b0;
        start = 1'b1;
        op    = OPC_MTLO;
        a     = 32'hCAFE_0001;
        @(negedge clk);
        start = 1'b0;
        checks++; if (lo !== 32'hCAFE_0001 || hi !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL first_edge_mtlo got lo=%08h hi=%08h busy=%b want lo=cafe0001 hi=0 busy=0", lo, hi, busy);
        end
        exp_hi = 32'h0;
        exp_lo = 32'hCAFE_0001;
    endtask

    typedef struct packed {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [5];
        int   cyc;
        logic dn;
        vecs[0] = '{OPC_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{OPC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{OPC_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OPC_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
        vecs[4] = '{OPC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, cyc, dn);
            checks++; if (cyc !== 32) begin errors++; $display("FAIL directed%0d busy_cycles got %0d want 32", i, cyc); end
            checks++; if (dn !== 1'b1) begin errors++; $display("FAIL directed%0d done got %b want 1", i, dn); end
            checks++; if (hi !== vecs[i].eh || lo !== vecs[i].el) begin
                errors++; $display("FAIL directed%0d hilo got %08h_%08h want %08h_%08h", i, hi, lo, vecs[i].eh, vecs[i].el);
            end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL directed%0d done_pulse_width got %b want 0", i, done); end
            exp_hi = vecs[i].eh;
            exp_lo = vecs[i].el;
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
        int          cyc;
        logic        dn;
        for (int i = 0; i < 32; i++) begin
            o = 3'(i % 4);
            x = pick();
            y = pick();
            e = ref_md(o, x, y);
            run_op(o, x, y, cyc, dn);
            checks++; if (cyc !== 32 || dn !== 1'b1) begin
                errors++; $display("FAIL random%0d timing got cycles=%0d done=%b want 32/1", i, cyc, dn);
            end
            checks++; if ({hi, lo} !== e) begin
                errors++; $display("FAIL random%0d op=%0d a=%08h b=%08h got %08h_%08h want %08h_%08h",
                                   i, o, x, y, hi, lo, e[63:32], e[31:0]);
            end
            exp_hi = e[63:32];
            exp_lo = e[31:0];
        end
    endtask

    task automatic test_mthi_cancel();
        logic seen_done;
        start = 1'b1;
        op    = OPC_MTHI;
        a     = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        checks++; if (hi !== 32'h1234_5678 || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mthi got hi=%08h lo=%08h busy=%b done=%b want hi=12345678 lo=%08h busy=0 done=0",
                               hi, lo, busy, done, exp_lo);
        end
        exp_hi = 32'h1234_5678;
        start = 1'b1;
        op    = OPC_MULT;
        a     = 32'd2;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin
                start = 1'b1;
                op    = OPC_MTLO;
                a     = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_cancel got %b want 1", busy); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", busy); end
        seen_done = 1'b0;
        repeat (40) begin
            seen_done |= (done === 1'b1);
            @(negedge clk);
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL cancel_done got %b want 0", seen_done); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL cancel_hilo got %08h_%08h want %08h_%08h", hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_cancel_at_end();
        start = 1'b1;
        op    = OPC_MULTU;
        a     = $urandom | 32'h1;
        b     = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL last_cycle_busy got %b want 1", busy); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL cancel_wins got done=%b busy=%b want 0/0", done, busy);
        end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL cancel_wins_hilo got %08h_%08h want %08h_%08h", hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_ignored_starts();
        logic bad;
        start  = 1'b1;
        cancel = 1'b1;
        op     = OPC_MTHI;
        a      = ~exp_hi;
        @(negedge clk);
        op = OPC_MULT;
        a  = 32'd9;
        b  = 32'd9;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        checks++; if (hi !== exp_hi || busy !== 1'b0) begin
            errors++; $display("FAIL start_with_cancel got hi=%08h busy=%b want hi=%08h busy=0", hi, busy, exp_hi);
        end
        bad = 1'b0;
        for (int r = 6; r < 8; r++) begin
            start = 1'b1;
            op    = 3'(r);
            a     = ~exp_lo;
            b     = 32'd3;
            @(negedge clk);
            start = 1'b0;
            bad |= (busy !== 1'b0) || (done !== 1'b0);
            @(negedge clk);
            bad |= (busy !== 1'b0) || (done !== 1'b0);
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reserved_op_activity got %b want 0", bad); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL reserved_op_hilo got %08h_%08h want %08h_%08h", hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        int   cyc;
        logic dn;
        start = 1'b1;
        op    = OPC_DIVU;
        a     = $urandom;
        b     = $urandom_range(1, 1000);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL async_reset got busy=%b done=%b hilo=%08h_%08h want 0/0/0_0", busy, done, hi, lo);
        end
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        seen   = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= (done === 1'b1) || (busy === 1'b1);
        end
        checks++; if (seen !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_discard got activity=%b hilo=%08h_%08h want 0 0_0", seen, hi, lo);
        end
        run_op(OPC_MULTU, 32'd4, 32'd4, cyc, dn);
        checks++; if (cyc !== 32 || dn !== 1'b1 || hi !== 32'h0 || lo !== 32'd16) begin
            errors++; $display("FAIL post_reset_multu got cycles=%0d done=%b hilo=%08h_%08h want 32/1 0_10",
                               cyc, dn, hi, lo);
        end
        exp_lo = 32'd16;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
        int          cyc;
        logic        dn;
        for (int i = 0; i < 4; i++) begin
            o = 3'($urandom_range(0, 3));
            x = pick();
            y = pick();
            e = ref_md(o, x, y);
            run_op(o, x, y, cyc, dn);
            checks++; if (cyc !== 32 || dn !== 1'b1) begin
                errors++; $display("FAIL b2b%0d timing got cycles=%0d done=%b want 32/1", i, cyc, dn);
            end
            checks++; if ({hi, lo} !== e) begin
                errors++; $display("FAIL b2b%0d op=%0d a=%08h b=%08h got %08h_%08h want %08h_%08h",
                                   i, o, x, y, hi, lo, e[63:32], e[31:0]);
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mthi_cancel();
        test_cancel_at_end();
        test_ignored_starts();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use clock `clk` and reset `reset`, which is asynchronous and active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled on the clk edge
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; other codes reserved
- a  in  32  operand A / dividend / MTHI-MTLO source (register-file read port 1 value)
- b  in  32  operand B / divisor (register-file read port 2 value)
- cancel  in  1  pipeline flush; aborts an in-flight operation
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an iterative operation
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 The block SHALL be a two-state FSM with states IDLE and RUN.
REQ-004 Start acceptance rules:
- start is accepted only in IDLE with cancel=0.
- start while busy is ignored.
- start with cancel=1 in the same cycle is ignored.
REQ-005 MTHI/MTLO behaviour:
- An accepted MTHI/MTLO SHALL write `a` into hi/lo at that edge.
- The state SHALL stay IDLE; busy and done SHALL stay 0.
REQ-006 Reserved op codes SHALL be accepted as no-ops: no state change and no hi/lo update.
REQ-007 Iterative ops (MULT, MULTU, DIV, DIVU):
- An accepted iterative op latches a, b and op at edge E0 and enters RUN.
- busy SHALL be 1 from after E0 through edge E32, i.e. exactly 32 cycles.
REQ-008 Datapath:
- One iteration per cycle: multiply is shift-add, divide is restoring shift-subtract.
- Datapath is 64-bit for multiply and 33-bit for divide (with remainder).
- The counter counts 0..31.
REQ-009 Completion at edge E32:
- hi/lo are written and the state returns to IDLE.
- done is 1 for exactly the cycle after E32.
- busy is 0 in that same cycle, so a new start may be accepted at that cycle's edge.
REQ-010 MULT/MULTU results:
- {hi,lo} SHALL equal the full 64-bit product.
- MULT is signed two's complement; MULTU is unsigned.
REQ-011 DIV/DIVU results:
- lo SHALL be the quotient and hi the remainder.
- Signed DIV truncates toward zero: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Signed operands are converted to magnitudes before iterating and sign-corrected at completion.
REQ-012 Divide by zero (b=0), DIV or DIVU: lo SHALL be 32'hFFFFFFFF and hi SHALL be `a`; the full 32-cycle latency still applies.
REQ-013 Signed overflow (DIV, a=32'h80000000, b=32'hFFFFFFFF): lo SHALL be 32'h80000000 and hi SHALL be 0.
REQ-014 Cancel:
- cancel=1 in RUN SHALL return the FSM to IDLE at the next edge.
- hi/lo are unchanged and done is not pulsed.
- If cancel coincides with E32, cancel wins.
REQ-015 hi/lo SHALL hold their values between updates; the operand inputs are not required to stay stable after E0.

Reset
REQ-016 Asserting reset SHALL immediately force:
- state IDLE, counter 0
- busy=0, done=0
- hi=32'h0, lo=32'h0
REQ-017 Reset asserted mid-operation SHALL discard the operation with no hi/lo update after reset is released.
REQ-018 The first start SHALL be accepted on the first rising clk edge with reset low.

Structure
REQ-019 Package muldiv_pkg SHALL hold:
- the op encodings
- the FSM state encoding
- constant MD_ITER=32
- constant MD_W=32
REQ-020 Sign pre-conversion and post-correction SHALL be a combinational sub-module `muldiv_signfix`; the FSM, counter and datapath SHALL live in muldiv_unit.

Verification
REQ-021 MULT a=32'hFFFFFFFD (-3), b=7 -> busy high exactly 32 cycles, done pulse, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-022 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-023 DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5; DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-024 MTHI a=32'h12345678, then MULT 2*3 started; cancel at cycle 10 -> hi=32'h12345678 and lo unchanged, no done; a start during busy is ignored.
REQ-025 Reset asserted at cycle 15 of a DIVU -> hi=lo=0 and busy=0 immediately; a new MULTU 4*4 started after reset release -> lo=16, hi=0.
REQ-026 Back-to-back: a start in the done cycle is accepted, busy is high the following cycle, and the second result is correct.
